conv_tap_addr_gen: RTL and testbench

Upstream stage of the neuron/plane ready counters in the conv datapath. For one input feature plane it walks every output pixel and, within each, every KxK kernel tap. Per tap it issues the input feature-map address and weight address to the MAC array via a valid/ready handshake. It flags the last tap of each neuron (the K*K-cycle boundary the ready counters count) and the last tap of the plane (the OUT_W*OUT_H boundary).

---
 rtl/conv_tap_addr_gen_if.sv | 38 +++
 rtl/conv_tap_addr_gen.sv | 164 ++++++++++++++++
 tb/tb_conv_tap_addr_gen.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_tap_addr_gen_if.sv
// Tap bus between the convolution address generator and the MAC array.
// The generator drives the master side; the MAC array drives tap_ready.
`timescale 1ns/1ps
interface conv_tap_addr_gen_if #(
    parameter int ADDR_W = 16,
    parameter int WA_W   = 5
);
    logic              tap_valid;
    logic              tap_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [WA_W-1:0]   w_addr;
    logic              tap_last;
    logic              plane_last;
    logic [7:0]        out_row;
    logic [7:0]        out_col;

    modport master (
        output tap_valid,
        output in_addr,
        output w_addr,
        output tap_last,
        output plane_last,
        output out_row,
        output out_col,
        input  tap_ready
    );

    modport slave (
        input  tap_valid,
        input  in_addr,
        input  w_addr,
        input  tap_last,
        input  plane_last,
        input  out_row,
        input  out_col,
        output tap_ready
    );
endinterface

// File: rtl/conv_tap_addr_gen.sv
// Walks every output pixel of one input plane and, within each, every KxK
// kernel tap, presenting feature-map and weight addresses on a valid/ready bus.
`timescale 1ns/1ps
module conv_tap_addr_gen #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int K      = 5,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    conv_tap_addr_gen_if.master  tap,
    output logic                 busy,
    output logic                 done
);
    localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
    localparam int WA_W  = (K * K > 1) ? $clog2(K * K) : 1;

    localparam logic [7:0] K_MAX  = 8'(K - 1);
    localparam logic [7:0] OC_MAX = 8'(OUT_W - 1);
    localparam logic [7:0] OR_MAX = 8'(OUT_H - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        kc_q, kc_d;
    logic [7:0]        kr_q, kr_d;
    logic [7:0]        oc_q, oc_d;
    logic [7:0]        orow_q, orow_d;

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] in_addr_q, in_addr_d;
    logic [WA_W-1:0]   w_addr_q, w_addr_d;
    logic              tap_last_q, tap_last_d;
    logic              plane_last_q, plane_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] offset_d;
    logic              kc_wrap, kr_wrap, oc_wrap, orow_wrap;

    assign kc_wrap   = (kc_q == K_MAX);
    assign kr_wrap   = (kr_q == K_MAX);
    assign oc_wrap   = (oc_q == OC_MAX);
    assign orow_wrap = (orow_q == OR_MAX);

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        kc_d         = kc_q;
        kr_d         = kr_q;
        oc_d         = oc_q;
        orow_d       = orow_q;
        done_d       = 1'b0;
        in_addr_d    = in_addr_q;
        w_addr_d     = w_addr_q;
        tap_last_d   = 1'b0;
        plane_last_d = 1'b0;
        offset_d     = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    base_d  = base_addr;
                    kc_d    = 8'd0;
                    kr_d    = 8'd0;
                    oc_d    = 8'd0;
                    orow_d  = 8'd0;
                end
            end
            S_RUN: begin
                if (tap.tap_ready) begin
                    if (plane_last_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // kc fastest, then kr, oc, row; each carry gates the next
                        kc_d = kc_wrap ? 8'd0 : kc_q + 8'd1;
                        if (kc_wrap) begin
                            kr_d = kr_wrap ? 8'd0 : kr_q + 8'd1;
                            if (kr_wrap) begin
                                oc_d = oc_wrap ? 8'd0 : oc_q + 8'd1;
                                if (oc_wrap) begin
                                    orow_d = orow_wrap ? 8'd0 : orow_q + 8'd1;
                                end
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        valid_d = (state_d == S_RUN);
        busy_d  = (state_d == S_RUN);

        // A stalled tap recomputes from held counters, so every output holds exactly
        if (state_d == S_RUN) begin
            offset_d     = ADDR_W'((32'(orow_d) * STRIDE + 32'(kr_d)) * IMG_W
                                   + 32'(oc_d) * STRIDE + 32'(kc_d));
            in_addr_d    = base_d + offset_d;
            w_addr_d     = WA_W'(32'(kr_d) * K + 32'(kc_d));
            tap_last_d   = (kr_d == K_MAX) && (kc_d == K_MAX);
            plane_last_d = tap_last_d && (oc_d == OC_MAX) && (orow_d == OR_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            kc_q         <= 8'd0;
            kr_q         <= 8'd0;
            oc_q         <= 8'd0;
            orow_q       <= 8'd0;
            valid_q      <= 1'b0;
            in_addr_q    <= '0;
            w_addr_q     <= '0;
            tap_last_q   <= 1'b0;
            plane_last_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            kc_q         <= kc_d;
            kr_q         <= kr_d;
            oc_q         <= oc_d;
            orow_q       <= orow_d;
            valid_q      <= valid_d;
            in_addr_q    <= in_addr_d;
            w_addr_q     <= w_addr_d;
            tap_last_q   <= tap_last_d;
            plane_last_q <= plane_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign tap.tap_valid  = valid_q;
    assign tap.in_addr    = in_addr_q;
    assign tap.w_addr     = w_addr_q;
    assign tap.tap_last   = tap_last_q;
    assign tap.plane_last = plane_last_q;
    assign tap.out_row    = orow_q;
    assign tap.out_col    = oc_q;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: tb/tb_conv_tap_addr_gen.sv
// Bench for conv_tap_addr_gen: a stride-1 and a stride-2 instance checked
// every cycle against an index-based model, plus hand-computed literal taps.
`timescale 1ns/1ps
module tb_conv_tap_addr_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_s [2];
    logic [15:0] base_s  [2];
    logic        ready_s [2];
    logic        busy_o  [2];
    logic        done_o  [2];
    logic        valid_o [2];
    logic [15:0] addr_o  [2];
    logic [4:0]  w_o     [2];
    logic        tl_o    [2];
    logic        pl_o    [2];
    logic [7:0]  row_o   [2];
    logic [7:0]  col_o   [2];

    conv_tap_addr_gen_if #(.ADDR_W(16), .WA_W(5)) if0 ();
    conv_tap_addr_gen_if #(.ADDR_W(16), .WA_W(5)) if1 ();

    assign if0.tap_ready = ready_s[0];
    assign if1.tap_ready = ready_s[1];

    conv_tap_addr_gen #(.IMG_W(32), .IMG_H(32), .K(5), .STRIDE(1), .ADDR_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .base_addr(base_s[0]),
        .tap(if0.master), .busy(busy_o[0]), .done(done_o[0])
    );
    conv_tap_addr_gen #(.IMG_W(32), .IMG_H(32), .K(5), .STRIDE(2), .ADDR_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .base_addr(base_s[1]),
        .tap(if1.master), .busy(busy_o[1]), .done(done_o[1])
    );

    assign valid_o[0] = if0.tap_valid;  assign valid_o[1] = if1.tap_valid;
    assign addr_o[0]  = if0.in_addr;    assign addr_o[1]  = if1.in_addr;
    assign w_o[0]     = if0.w_addr;     assign w_o[1]     = if1.w_addr;
    assign tl_o[0]    = if0.tap_last;   assign tl_o[1]    = if1.tap_last;
    assign pl_o[0]    = if0.plane_last; assign pl_o[1]    = if1.plane_last;
    assign row_o[0]   = if0.out_row;    assign row_o[1]   = if1.out_row;
    assign col_o[0]   = if0.out_col;    assign col_o[1]   = if1.out_col;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: index of the tap currently presented, per instance
    bit m_run    [2];
    bit m_done   [2];
    int m_idx    [2];
    int m_base   [2];
    int obs_acc  [2];
    int done_cnt [2];

    task automatic chk(input int d, input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     d, nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic int out_dim(input int d);
        return (32 - 5) / (d + 1) + 1;
    endfunction

    function automatic int total_taps(input int d);
        return 25 * out_dim(d) * out_dim(d);
    endfunction

    // Expected tap fields straight from the tap index
    task automatic exp_fields(input int d, input int idx, input int base,
                              output int addr, output int w, output int tl,
                              output int pl, output int row, output int col);
        int s, ow, nrn, k, kr, kc;
        s   = d + 1;
        ow  = out_dim(d);
        nrn = idx / 25;
        k   = idx % 25;
        kr  = k / 5;
        kc  = k % 5;
        row = nrn / ow;
        col = nrn % ow;
        addr = (base + (row * s + kr) * 32 + col * s + kc) & 32'hFFFF;
        w    = k;
        tl   = (k == 24) ? 1 : 0;
        pl   = (idx == total_taps(d) - 1) ? 1 : 0;
    endtask

    always @(negedge clk) begin
        int e_addr, e_w, e_tl, e_pl, e_row, e_col;
        bit nd;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_run[d]   = 1'b0;
                m_done[d]  = 1'b0;
                m_idx[d]   = 0;
                obs_acc[d] = 0;
            end else begin
                chk(d, "tap_valid", int'(valid_o[d]), int'(m_run[d]));
                chk(d, "busy", int'(busy_o[d]), int'(m_run[d]));
                chk(d, "done", int'(done_o[d]), int'(m_done[d]));
                if (done_o[d]) begin
                    done_cnt[d]++;
                    chk(d, "accepted_taps", obs_acc[d], total_taps(d));
                end
                if (m_run[d]) begin
                    exp_fields(d, m_idx[d], m_base[d], e_addr, e_w, e_tl, e_pl, e_row, e_col);
                    chk(d, "in_addr", int'(addr_o[d]), e_addr);
                    chk(d, "w_addr", int'(w_o[d]), e_w);
                    chk(d, "tap_last", int'(tl_o[d]), e_tl);
                    chk(d, "plane_last", int'(pl_o[d]), e_pl);
                    chk(d, "out_row", int'(row_o[d]), e_row);
                    chk(d, "out_col", int'(col_o[d]), e_col);
                end
                if (valid_o[d] && ready_s[d]) obs_acc[d]++;
                nd = 1'b0;
                if (m_run[d] && ready_s[d]) begin
                    if (m_idx[d] == total_taps(d) - 1) begin
                        m_run[d] = 1'b0;
                        nd = 1'b1;
                    end else begin
                        m_idx[d]++;
                    end
                end else if (!m_run[d] && !m_done[d] && start_s[d]) begin
                    m_run[d]   = 1'b1;
                    m_idx[d]   = 0;
                    obs_acc[d] = 0;
                    m_base[d]  = int'(base_s[d]);
                end
                m_done[d] = nd;
            end
        end
    end

    // Hand-computed taps that pin the model itself
    task automatic literal_checks(input int d, input logic [15:0] base, input int idx);
        if (d == 0 && base == 16'h0000) begin
            if (idx == 0)     chk(d, "lit_t0_addr", int'(addr_o[d]), 0);
            if (idx == 5)     begin chk(d, "lit_t5_addr", int'(addr_o[d]), 32);
                                    chk(d, "lit_t5_w", int'(w_o[d]), 5); end
            if (idx == 24)    begin chk(d, "lit_t24_addr", int'(addr_o[d]), 132);
                                    chk(d, "lit_t24_w", int'(w_o[d]), 24);
                                    chk(d, "lit_t24_last", int'(tl_o[d]), 1); end
            if (idx == 25)    begin chk(d, "lit_t25_addr", int'(addr_o[d]), 1);
                                    chk(d, "lit_t25_col", int'(col_o[d]), 1); end
            if (idx == 700)   begin chk(d, "lit_n28_addr", int'(addr_o[d]), 32);
                                    chk(d, "lit_n28_row", int'(row_o[d]), 1);
                                    chk(d, "lit_n28_col", int'(col_o[d]), 0); end
            if (idx == 19599) begin chk(d, "lit_last_addr", int'(addr_o[d]), 1023);
                                    chk(d, "lit_last_pl", int'(pl_o[d]), 1); end
        end
        if (d == 0 && base == 16'h0200) begin
            if (idx == 0)  chk(d, "lit_restart_addr", int'(addr_o[d]), 16'h0200);
            if (idx == 10) begin chk(d, "lit_t10_addr", int'(addr_o[d]), 16'h0240);
                                 chk(d, "lit_t10_w", int'(w_o[d]), 10); end
        end
        if (d == 1) begin
            if (idx == 0)    chk(d, "lit_s2_t0_addr", int'(addr_o[d]), 16'h1000);
            if (idx == 25)   chk(d, "lit_s2_n1_addr", int'(addr_o[d]), 16'h1002);
            if (idx == 4899) begin chk(d, "lit_s2_last_addr", int'(addr_o[d]), 16'h13DE);
                                   chk(d, "lit_s2_last_pl", int'(pl_o[d]), 1); end
        end
    endtask

    task automatic run_plane(input int d, input logic [15:0] base, input int stall_at,
                             input int reset_at, input bit repulse);
        int  dc0, stall_n, idx;
        bit  fin;
        dc0     = done_cnt[d];
        stall_n = 0;
        fin     = 1'b0;
        @(posedge clk); #1;
        base_s[d]  = base;
        start_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        base_s[d]  = 16'hBEEF;
        for (int cyc = 0; cyc < 25000 && !fin; cyc++) begin
            idx = m_idx[d];
            if (done_o[d]) begin
                fin = 1'b1;
                ready_s[d] = 1'b1;
                if (repulse) start_s[d] = 1'b1;
                @(posedge clk); #1;
                start_s[d] = 1'b0;
                chk(d, "post_done_busy", int'(busy_o[d]), 0);
                chk(d, "post_done_valid", int'(valid_o[d]), 0);
                chk(d, "post_done_done", int'(done_o[d]), 0);
                repeat (3) @(posedge clk);
                #1;
                chk(d, "done_pulses", done_cnt[d] - dc0, 1);
                chk(d, "idle_busy", int'(busy_o[d]), 0);
            end else begin
                if (m_run[d]) literal_checks(d, base, idx);
                if (idx == stall_at && stall_n < 3) begin
                    ready_s[d] = 1'b0;
                    stall_n++;
                end else begin
                    ready_s[d] = 1'b1;
                end
                if (repulse) start_s[d] = (idx == 100);
                if (idx == reset_at) begin
                    #2 rst_n = 1'b0;
                    #1;
                    chk(d, "rst_valid", int'(valid_o[d]), 0);
                    chk(d, "rst_in_addr", int'(addr_o[d]), 0);
                    chk(d, "rst_w_addr", int'(w_o[d]), 0);
                    chk(d, "rst_busy", int'(busy_o[d]), 0);
                    chk(d, "rst_out_col", int'(col_o[d]), 0);
                    @(negedge clk); #1;
                    rst_n = 1'b1;
                    repeat (3) @(posedge clk);
                    #1;
                    chk(d, "rst_no_done", done_cnt[d] - dc0, 0);
                    chk(d, "rst_idle_busy", int'(busy_o[d]), 0);
                    fin = 1'b1;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
        if (!fin) chk(d, "plane_timeout", 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_s[d]  = 1'b0;
            base_s[d]   = 16'h0000;
            ready_s[d]  = 1'b1;
            done_cnt[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(0, "reset_valid", int'(valid_o[0]), 0);
        chk(0, "reset_in_addr", int'(addr_o[0]), 0);
        chk(0, "reset_w_addr", int'(w_o[0]), 0);
        chk(0, "reset_busy", int'(busy_o[0]), 0);
        chk(0, "reset_done", int'(done_o[0]), 0);
        chk(1, "reset_in_addr", int'(addr_o[1]), 0);
        rst_n = 1'b1;

        run_plane(0, 16'h0000, -1, -1, 1'b1);
        run_plane(0, 16'h0200, -1, 500, 1'b0);
        run_plane(0, 16'h0200, 10, -1, 1'b0);
        run_plane(1, 16'h1000, -1, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
